metrics_counter_bank: RTL and testbench

// Bank of NUM_CNT independent performance counters; generalised successor of the single cycle timer
// in the SoC control-register block. Each channel counts cycles (timer mode) or weighted events
// (event mode). Adds wrap/saturate overflow handling, sticky overflow flags and an atomic
// all-channel snapshot for coherent software readout. Sits beside the AXI-lite ctrl regs, which

---
 rtl/metrics_counter_bank.sv | 117 +++++++++++
 tb/tb_metrics_counter_bank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/metrics_counter_bank.sv
// Bank of independent cycle/event counters with wrap-or-saturate overflow,
// sticky overflow flags and an atomic all-channel snapshot register.
module metrics_counter_bank #(
  parameter int                 NUM_CNT       = 4,
  parameter int                 COUNTER_WIDTH = 64,
  parameter int                 INC_WIDTH     = 4,
  parameter logic [NUM_CNT-1:0] CYCLE_MASK    = 'h1,
  parameter bit                 SATURATE      = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CNT-1:0]               en,
  input  logic [NUM_CNT-1:0]               clear,
  input  logic [NUM_CNT*INC_WIDTH-1:0]     evt_inc,
  input  logic                             snap,
  input  logic                             snap_clr,
  output logic [NUM_CNT*COUNTER_WIDTH-1:0] cnt_live,
  output logic [NUM_CNT*COUNTER_WIDTH-1:0] cnt_snap,
  output logic [NUM_CNT-1:0]               ovf,
  output logic                             snap_valid
);

  localparam int SUM_W = COUNTER_WIDTH + 1;

  if (NUM_CNT < 1 || NUM_CNT > 32) begin : g_bad_num_cnt
    $error("metrics_counter_bank: NUM_CNT must be in 1..32");
  end
  if (INC_WIDTH < 1 || INC_WIDTH > COUNTER_WIDTH) begin : g_bad_inc_width
    $error("metrics_counter_bank: INC_WIDTH must be 1..COUNTER_WIDTH");
  end
  if (COUNTER_WIDTH < 8 || COUNTER_WIDTH > 64 || (COUNTER_WIDTH % 8) != 0) begin : g_bad_cnt_width
    $error("metrics_counter_bank: COUNTER_WIDTH must be a multiple of 8 in 8..64");
  end

  logic [COUNTER_WIDTH-1:0] cnt_q  [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] cnt_d  [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] snap_q [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] snap_d [NUM_CNT];
  logic [NUM_CNT-1:0]       ovf_q;
  logic [NUM_CNT-1:0]       ovf_d;
  logic                     snap_valid_q;
  logic                     snap_valid_d;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ch
    logic [SUM_W-1:0]         inc_ext;
    logic [SUM_W-1:0]         sum;
    logic [COUNTER_WIDTH-1:0] cnt_nxt;
    logic                     ovf_nxt;

    // The extra top bit of sum is the carry that marks an overflow.
    always_comb begin
      inc_ext = '0;
      if (CYCLE_MASK[g]) begin
        inc_ext = SUM_W'(1);
      end else begin
        inc_ext = SUM_W'(evt_inc[g*INC_WIDTH +: INC_WIDTH]);
      end
      sum = {1'b0, cnt_q[g]} + inc_ext;
    end

    always_comb begin
      cnt_nxt = cnt_q[g];
      ovf_nxt = ovf_q[g];
      if (clear[g]) begin
        cnt_nxt = '0;
        ovf_nxt = 1'b0;
      end else if (en[g]) begin
        if (sum[COUNTER_WIDTH]) begin
          ovf_nxt = 1'b1;
          cnt_nxt = SATURATE ? '1 : sum[COUNTER_WIDTH-1:0];
        end else begin
          cnt_nxt = sum[COUNTER_WIDTH-1:0];
        end
      end
    end

    assign cnt_d[g] = cnt_nxt;
    assign ovf_d[g] = ovf_nxt;

    assign cnt_live[g*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q[g];
    assign cnt_snap[g*COUNTER_WIDTH +: COUNTER_WIDTH] = snap_q[g];
  end

  // Snapshot handshake: snap copies the pre-update counters of every channel
  // and raises snap_valid; software reads cnt_snap, then pulses snap_clr.
  // snap beats snap_clr, and a snap while valid simply overwrites.
  always_comb begin
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    if (snap) begin
      snap_d       = cnt_q;
      snap_valid_d = 1'b1;
    end else if (snap_clr) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign ovf        = ovf_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Bench for metrics_counter_bank: an 8-bit wrapping bank and an 8-bit
// saturating bank share one stimulus stream and are checked side by side.
module tb_metrics_counter_bank;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    en;
  logic [N-1:0]    clear;
  logic [N*IW-1:0] evt_inc;
  logic            snap;
  logic            snap_clr;
  logic [N*W-1:0]  live_w, snap_w, live_s, snap_s;
  logic [N-1:0]    ovf_w, ovf_s;
  logic            sv_w, sv_s;

  always #5 clk = ~clk;

  metrics_counter_bank #(
    .NUM_CNT(N), .COUNTER_WIDTH(W), .INC_WIDTH(IW), .CYCLE_MASK(4'b0001), .SATURATE(1'b0)
  ) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .evt_inc(evt_inc),
    .snap(snap), .snap_clr(snap_clr),
    .cnt_live(live_w), .cnt_snap(snap_w), .ovf(ovf_w), .snap_valid(sv_w)
  );

  metrics_counter_bank #(
    .NUM_CNT(N), .COUNTER_WIDTH(W), .INC_WIDTH(IW), .CYCLE_MASK(4'b0001), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .evt_inc(evt_inc),
    .snap(snap), .snap_clr(snap_clr),
    .cnt_live(live_s), .cnt_snap(snap_s), .ovf(ovf_s), .snap_valid(sv_s)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  // status word layout: {ovf_sat, ovf_wrap, snap_valid_sat, snap_valid_wrap}
  function automatic logic [31:0] status();
    return 32'({ovf_s, ovf_w, sv_s, sv_w});
  endfunction

  function automatic logic [31:0] st(input logic [N-1:0] o, input logic v);
    return 32'({o, o, v, v});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = '0; clear = '0; evt_inc = '0; snap = 1'b0; snap_clr = 1'b0;
  endtask

  task automatic set_inc(input int ch, input int v);
    evt_inc[ch*IW +: IW] = IW'(v);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1;
      en = 4'($urandom); clear = 4'($urandom); evt_inc = 16'($urandom);
      snap = 1'b1; snap_clr = 1'($urandom);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL reset_live_w got=%h want=%h", live_w, e); end
      e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL reset_live_s got=%h want=%h", live_s, e); end
      e = exp_q.pop_front(); n_cmp++; if (snap_w !== e) begin n_bad++; $display("FAIL reset_snap_w got=%h want=%h", snap_w, e); end
      e = exp_q.pop_front(); n_cmp++; if (snap_s !== e) begin n_bad++; $display("FAIL reset_snap_s got=%h want=%h", snap_s, e); end
      e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL reset_status got=%h want=%h", status(), e); end
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_timer();
    idle();
    en = 4'b0001;
    set_inc(0, 7);
    exp_q.push_back(32'd100); exp_q.push_back(32'd100); exp_q.push_back(32'h0);
    repeat (100) tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL timer_live_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL timer_live_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL timer_status got=%h want=%h", status(), e); end
    en = '0;
    exp_q.push_back(32'd100); exp_q.push_back(32'd100);
    repeat (3) tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL timer_hold_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL timer_hold_s got=%h want=%h", live_s, e); end
  endtask

  task automatic test_event();
    idle();
    en = 4'b0010;
    set_inc(1, 3);
    repeat (10) tick();
    set_inc(1, 15);
    exp_q.push_back(32'h0000_3C64); exp_q.push_back(32'h0000_3C64);
    repeat (2) tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL event_live_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL event_live_s got=%h want=%h", live_s, e); end
    clear = 4'b0011;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL event_clear_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL event_clear_s got=%h want=%h", live_s, e); end
    idle();
  endtask

  task automatic test_overflow();
    idle();
    en = 4'b0010;
    set_inc(1, 15);
    repeat (16) tick();
    set_inc(1, 10);
    exp_q.push_back(32'h0000_FA00); exp_q.push_back(32'h0000_FA00);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL ovf_pre_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL ovf_pre_s got=%h want=%h", live_s, e); end
    set_inc(1, 9);
    exp_q.push_back(32'h0000_0300); exp_q.push_back(32'h0000_FF00); exp_q.push_back(st(4'b0010, 1'b0));
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL ovf_wrap_val got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL ovf_sat_val got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL ovf_flag got=%h want=%h", status(), e); end
    set_inc(1, 0);
    exp_q.push_back(32'h0000_0300); exp_q.push_back(32'h0000_FF00); exp_q.push_back(st(4'b0010, 1'b0));
    repeat (3) tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL ovf_inc0_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL ovf_inc0_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL ovf_inc0_flag got=%h want=%h", status(), e); end
    set_inc(1, 1);
    exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h0000_FF00);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL ovf_after_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL ovf_stuck_s got=%h want=%h", live_s, e); end
    en = '0;
    exp_q.push_back(st(4'b0010, 1'b0));
    repeat (5) tick();
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL ovf_sticky got=%h want=%h", status(), e); end
    clear = 4'b0010;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL ovf_clr_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL ovf_clr_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL ovf_clr_flag got=%h want=%h", status(), e); end
    // ch2 reaches exactly all-ones without a carry, then sees inc 0 and inc 1
    idle();
    en = 4'b0100;
    set_inc(2, 15);
    repeat (17) tick();
    set_inc(2, 0);
    exp_q.push_back(32'h00FF_0000); exp_q.push_back(32'h00FF_0000); exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL full_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL full_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL full_noovf got=%h want=%h", status(), e); end
    set_inc(2, 1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h00FF_0000); exp_q.push_back(st(4'b0100, 1'b0));
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL full_wrap_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL full_sat_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL full_ovf got=%h want=%h", status(), e); end
    idle();
    clear = 4'b0100;
    tick();
    idle();
  endtask

  task automatic test_snapshot();
    idle();
    clear = 4'b1111;
    tick();
    idle();
    en = 4'b0011;
    set_inc(1, 15);
    tick();
    set_inc(1, 2);
    tick();
    set_inc(1, 0);
    exp_q.push_back(32'h0000_1128);
    repeat (38) tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL snap_pre_live got=%h want=%h", live_w, e); end
    snap = 1'b1; clear = 4'b0010; set_inc(1, 5);
    exp_q.push_back(32'h0000_1128); exp_q.push_back(32'h0000_1128);
    exp_q.push_back(32'h0000_0029); exp_q.push_back(st(4'b0000, 1'b1));
    tick();
    e = exp_q.pop_front(); n_cmp++; if (snap_w !== e) begin n_bad++; $display("FAIL snap_cap_w got=%h want=%h", snap_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (snap_s !== e) begin n_bad++; $display("FAIL snap_cap_s got=%h want=%h", snap_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL snap_clr_live got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL snap_valid_set got=%h want=%h", status(), e); end
    idle();
    snap_clr = 1'b1;
    exp_q.push_back(32'h0000_1128); exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (snap_w !== e) begin n_bad++; $display("FAIL snapclr_keep got=%h want=%h", snap_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL snapclr_valid got=%h want=%h", status(), e); end
    snap = 1'b1; snap_clr = 1'b1;
    exp_q.push_back(32'h0000_0029); exp_q.push_back(st(4'b0000, 1'b1));
    tick();
    e = exp_q.pop_front(); n_cmp++; if (snap_w !== e) begin n_bad++; $display("FAIL snap_wins_val got=%h want=%h", snap_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL snap_wins_valid got=%h want=%h", status(), e); end
    idle();
    en = 4'b0001;
    tick();
    idle();
    snap = 1'b1;
    exp_q.push_back(32'h0000_002A); exp_q.push_back(st(4'b0000, 1'b1));
    tick();
    e = exp_q.pop_front(); n_cmp++; if (snap_s !== e) begin n_bad++; $display("FAIL snap_overwrite got=%h want=%h", snap_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL snap_overwrite_valid got=%h want=%h", status(), e); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    en = 4'b1000;
    set_inc(3, 15);
    exp_q.push_back(32'h0E00_002A); exp_q.push_back(32'hFF00_002A); exp_q.push_back(st(4'b1000, 1'b1));
    repeat (18) tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL mid_pre_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL mid_pre_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL mid_pre_status got=%h want=%h", status(), e); end
    rst = 1'b1; snap = 1'b1; en = 4'b1111; evt_inc = '1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL mid_rst_live_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL mid_rst_live_s got=%h want=%h", live_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (snap_w !== e) begin n_bad++; $display("FAIL mid_rst_snap_w got=%h want=%h", snap_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (snap_s !== e) begin n_bad++; $display("FAIL mid_rst_snap_s got=%h want=%h", snap_s, e); end
    e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL mid_rst_status got=%h want=%h", status(), e); end
    rst = 1'b0;
    idle();
    en = 4'b0001;
    exp_q.push_back(32'h0000_0001); exp_q.push_back(32'h0000_0001);
    tick();
    e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL mid_resume_w got=%h want=%h", live_w, e); end
    e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL mid_resume_s got=%h want=%h", live_s, e); end
    idle();
  endtask

  task automatic test_random();
    int          mw[N];
    int          ms[N];
    logic [N-1:0] ow, os;
    logic [31:0] snw, sns, pw, ps;
    logic        msv;
    int          inc;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int c = 0; c < N; c++) begin mw[c] = 0; ms[c] = 0; end
    ow = '0; os = '0; snw = '0; sns = '0; msv = 1'b0;
    repeat (300) begin
      en       = 4'($urandom);
      clear    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      evt_inc  = 16'($urandom);
      snap     = ($urandom_range(0, 7) == 0);
      snap_clr = ($urandom_range(0, 5) == 0);
      for (int c = 0; c < N; c++) begin
        pw[c*W +: W] = W'(mw[c]);
        ps[c*W +: W] = W'(ms[c]);
      end
      if (snap) begin
        snw = pw; sns = ps; msv = 1'b1;
      end else if (snap_clr) begin
        msv = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
        if (clear[c]) begin
          mw[c] = 0; ms[c] = 0; ow[c] = 1'b0; os[c] = 1'b0;
        end else if (en[c]) begin
          inc = (c == 0) ? 1 : int'(evt_inc[c*IW +: IW]);
          if (mw[c] + inc > 255) begin mw[c] = mw[c] + inc - 256; ow[c] = 1'b1; end
          else mw[c] = mw[c] + inc;
          if (ms[c] + inc > 255) begin ms[c] = 255; os[c] = 1'b1; end
          else ms[c] = ms[c] + inc;
        end
      end
      for (int c = 0; c < N; c++) begin
        pw[c*W +: W] = W'(mw[c]);
        ps[c*W +: W] = W'(ms[c]);
      end
      exp_q.push_back(pw); exp_q.push_back(ps); exp_q.push_back(snw); exp_q.push_back(sns);
      exp_q.push_back(32'({os, ow, msv, msv}));
      tick();
      e = exp_q.pop_front(); n_cmp++; if (live_w !== e) begin n_bad++; $display("FAIL rand_live_w got=%h want=%h", live_w, e); end
      e = exp_q.pop_front(); n_cmp++; if (live_s !== e) begin n_bad++; $display("FAIL rand_live_s got=%h want=%h", live_s, e); end
      e = exp_q.pop_front(); n_cmp++; if (snap_w !== e) begin n_bad++; $display("FAIL rand_snap_w got=%h want=%h", snap_w, e); end
      e = exp_q.pop_front(); n_cmp++; if (snap_s !== e) begin n_bad++; $display("FAIL rand_snap_s got=%h want=%h", snap_s, e); end
      e = exp_q.pop_front(); n_cmp++; if (status() !== e) begin n_bad++; $display("FAIL rand_status got=%h want=%h", status(), e); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    test_reset();
    test_timer();
    test_event();
    test_overflow();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
